// File: rtl/fusa_mem_pkg.sv
// Shared definitions for the ECC-protected memory responders:
// codeword widths, response codes and responder FSM states.
package fusa_mem_pkg;

  localparam int unsigned ECC_DATA_W = 32;
  localparam int unsigned ECC_CODE_W = 39;

  localparam logic [1:0] RSP_OK   = 2'b00;
  localparam logic [1:0] RSP_CE   = 2'b01;
  localparam logic [1:0] RSP_UE   = 2'b10;
  localparam logic [1:0] RSP_ADDR = 2'b11;

  typedef enum logic [1:0] {
    ST_INIT,
    ST_IDLE,
    ST_WAIT,
    ST_RESP
  } dmem_state_e;

endpackage

// File: rtl/ecc_secded_32.sv
// Combinational (39,32) SECDED Hamming codec: check bits at positions 1,2,4,8,16,32,
// data in the remaining positions 1..38 ascending, bit 0 = overall even parity.
module ecc_secded_32
  import fusa_mem_pkg::*;
(
  input  logic [ECC_DATA_W-1:0] enc_data,
  output logic [ECC_CODE_W-1:0] enc_code,
  input  logic [ECC_CODE_W-1:0] dec_code,
  output logic [ECC_DATA_W-1:0] dec_data,
  output logic [5:0]            dec_syndrome,
  output logic                  dec_ce,
  output logic                  dec_ue
);

  always_comb begin
    int unsigned k;
    logic par;
    enc_code = '0;
    k = 0;
    par = 1'b0;
    for (int unsigned p = 1; p < ECC_CODE_W; p++) begin
      if ((p & (p - 1)) != 0) begin
        enc_code[p] = enc_data[k];
        k = k + 1;
      end
    end
    // Each check position is still zero while its own parity is gathered.
    for (int unsigned i = 0; i < 6; i++) begin
      par = 1'b0;
      for (int unsigned p = 1; p < ECC_CODE_W; p++) begin
        if (((p >> i) & 1) != 0) par = par ^ enc_code[p];
      end
      enc_code[1 << i] = par;
    end
    enc_code[0] = ^enc_code[ECC_CODE_W-1:1];
  end

  always_comb begin
    int unsigned k;
    logic [ECC_CODE_W-1:0] fixed;
    logic par_err;
    dec_syndrome = '0;
    for (int unsigned p = 1; p < ECC_CODE_W; p++) begin
      if (dec_code[p]) dec_syndrome = dec_syndrome ^ 6'(p);
    end
    par_err = ^dec_code;
    fixed   = dec_code;
    dec_ce  = 1'b0;
    dec_ue  = 1'b0;
    if (dec_syndrome > 6'd38) begin
      dec_ue = 1'b1;
    end else if (par_err) begin
      dec_ce = 1'b1;
      fixed[dec_syndrome] = ~fixed[dec_syndrome];
    end else if (dec_syndrome != '0) begin
      dec_ue = 1'b1;
    end
    dec_data = '0;
    k = 0;
    for (int unsigned p = 1; p < ECC_CODE_W; p++) begin
      if ((p & (p - 1)) != 0) begin
        dec_data[k] = fixed[p];
        k = k + 1;
      end
    end
  end

endmodule

// File: rtl/dmem_ecc_responder.sv
// SECDED-protected data-memory responder: one outstanding load/store, programmable
// wait states, scrub-on-read of single-bit errors, saturating CE/UE counters.
module dmem_ecc_responder
  import fusa_mem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned WAIT_STATES = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [31:0]           req_addr,
  input  logic [31:0]           req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [31:0]           rsp_rdata,
  output logic [1:0]            rsp_err,
  output logic [15:0]           ce_count,
  output logic [15:0]           ue_count,
  input  logic [ECC_CODE_W-1:0] inject_mask
);

  localparam int unsigned AW         = $clog2(DEPTH_WORDS);
  localparam logic [31:0] ADDR_LIMIT = 32'(4 * DEPTH_WORDS);

  dmem_state_e state, state_n;
  logic [AW-1:0] sweep;
  logic [3:0]    wait_cnt, wait_n;
  logic          write_q, bad_q;
  logic [AW-1:0] idx_q;

  logic [ECC_CODE_W-1:0] mem [DEPTH_WORDS];

  logic                  accept, req_bad, enter_resp, load_hit;
  logic [AW-1:0]         req_idx, cur_idx;
  logic                  cur_write, cur_bad;
  logic [ECC_CODE_W-1:0] rd_code, enc_code, scrub_code;
  logic [ECC_DATA_W-1:0] dec_data;
  logic [5:0]            dec_syndrome;
  logic                  dec_ce, dec_ue;
  logic                  mem_we;
  logic [AW-1:0]         mem_waddr;
  logic [ECC_CODE_W-1:0] mem_wdata;

  assign req_ready = (state == ST_IDLE);
  assign rsp_valid = (state == ST_RESP);
  assign accept    = req_ready && req_valid;
  assign req_bad   = (req_addr[1:0] != 2'b00) || (req_addr >= ADDR_LIMIT);
  assign req_idx   = req_addr[AW+1:2];

  // With zero wait states the load decodes on the accept cycle, before the latches fill.
  assign cur_write = (state == ST_IDLE) ? req_write : write_q;
  assign cur_bad   = (state == ST_IDLE) ? req_bad   : bad_q;
  assign cur_idx   = (state == ST_IDLE) ? req_idx   : idx_q;
  assign rd_code   = mem[cur_idx];

  ecc_secded_32 u_ecc (
    .enc_data     (req_wdata),
    .enc_code     (enc_code),
    .dec_code     (rd_code),
    .dec_data     (dec_data),
    .dec_syndrome (dec_syndrome),
    .dec_ce       (dec_ce),
    .dec_ue       (dec_ue)
  );

  assign scrub_code = rd_code ^ ({{(ECC_CODE_W-1){1'b0}}, 1'b1} << dec_syndrome);

  always_comb begin
    state_n = state;
    wait_n  = wait_cnt;
    unique case (state)
      ST_INIT: if (sweep == AW'(DEPTH_WORDS - 1)) state_n = ST_IDLE;
      ST_IDLE: begin
        if (req_valid) begin
          if (WAIT_STATES == 0) begin
            state_n = ST_RESP;
          end else begin
            state_n = ST_WAIT;
            wait_n  = 4'(WAIT_STATES);
          end
        end
      end
      ST_WAIT: begin
        if (wait_cnt <= 4'd1) state_n = ST_RESP;
        else                  wait_n  = wait_cnt - 4'd1;
      end
      ST_RESP: if (rsp_ready) state_n = ST_IDLE;
      default: state_n = ST_INIT;
    endcase
  end

  assign enter_resp = (state_n == ST_RESP) && (state != ST_RESP);
  assign load_hit   = enter_resp && !cur_write && !cur_bad;

  // Single write port shared by init sweep, stores and scrub; the sources never overlap.
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = sweep;
    mem_wdata = '0;
    if (!reset) begin
      if (state == ST_INIT) begin
        mem_we = 1'b1;
      end else if (accept && req_write && !req_bad) begin
        mem_we    = 1'b1;
        mem_waddr = req_idx;
        mem_wdata = enc_code ^ inject_mask;
      end else if (load_hit && dec_ce) begin
        mem_we    = 1'b1;
        mem_waddr = cur_idx;
        mem_wdata = scrub_code;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_INIT;
      sweep     <= '0;
      wait_cnt  <= '0;
      write_q   <= 1'b0;
      bad_q     <= 1'b0;
      idx_q     <= '0;
      rsp_rdata <= '0;
      rsp_err   <= RSP_OK;
      ce_count  <= '0;
      ue_count  <= '0;
    end else begin
      state    <= state_n;
      wait_cnt <= wait_n;
      if (state == ST_INIT) sweep <= sweep + 1'b1;
      if (accept) begin
        write_q <= req_write;
        bad_q   <= req_bad;
        idx_q   <= req_idx;
      end
      if (enter_resp) begin
        if (cur_bad) begin
          rsp_rdata <= '0;
          rsp_err   <= RSP_ADDR;
        end else if (cur_write) begin
          rsp_rdata <= '0;
          rsp_err   <= RSP_OK;
        end else if (dec_ue) begin
          rsp_rdata <= '0;
          rsp_err   <= RSP_UE;
          if (ue_count != '1) ue_count <= ue_count + 16'd1;
        end else begin
          rsp_rdata <= dec_data;
          rsp_err   <= dec_ce ? RSP_CE : RSP_OK;
          if (dec_ce && ce_count != '1) ce_count <= ce_count + 16'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_dmem_ecc_responder.sv
// Bench for dmem_ecc_responder: directed vector table, backpressure/reset sequences,
// then random traffic against a word-plus-fault-mask reference model.
module tb_dmem_ecc_responder;

  localparam int unsigned DEPTH = 256;
  localparam int unsigned WS    = 1;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready, req_write;
  logic [31:0] req_addr, req_wdata;
  logic        rsp_valid, rsp_ready;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_err;
  logic [15:0] ce_count, ue_count;
  logic [38:0] inject_mask;

  always #5 clk = ~clk;

  dmem_ecc_responder #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(WS)) dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_write   (req_write),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_rdata   (rsp_rdata),
    .rsp_err     (rsp_err),
    .ce_count    (ce_count),
    .ue_count    (ue_count),
    .inject_mask (inject_mask)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // One request with rsp_ready held high; returns data, error code and latency in cycles.
  task automatic txn(input logic w, input logic [31:0] a, input logic [31:0] d,
                     input logic [38:0] m, output logic [31:0] rd, output logic [1:0] er,
                     output int lat);
    int n;
    @(negedge clk);
    req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d; inject_mask = m;
    n = 0;
    while (!req_ready && n < 1000) begin @(negedge clk); n++; end
    check("accept_ready", req_ready, 1);
    @(posedge clk); #1;
    req_valid = 1'b0; inject_mask = '0;
    lat = 0;
    while (lat < 100) begin
      @(negedge clk); lat++;
      if (rsp_valid) break;
    end
    check("rsp_valid_seen", rsp_valid, 1);
    rd = rsp_rdata; er = rsp_err;
    @(posedge clk); #1;
  endtask

  typedef struct {
    logic        w;
    logic [31:0] a;
    logic [31:0] d;
    logic [38:0] m;
    logic [31:0] exp_rd;
    logic [1:0]  exp_err;
    logic [15:0] exp_ce;
    logic [15:0] exp_ue;
  } vec_t;

  vec_t tbl [15];

  logic [31:0] m_data [DEPTH];
  logic [38:0] m_mask [DEPTH];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd, hold_rd;
    logic [1:0]  er, hold_er;
    int          lat, cnt, n;
    logic        saw_valid;
    int unsigned exp_ce, exp_ue;

    tbl[0]  = '{1'b0, 32'h0000_0000, 32'h0,          39'h0,  32'h0,          2'b00, 16'd0, 16'd0};
    tbl[1]  = '{1'b1, 32'h0000_0010, 32'hDEAD_BEEF,  39'h0,  32'h0,          2'b00, 16'd0, 16'd0};
    tbl[2]  = '{1'b0, 32'h0000_0010, 32'h0,          39'h0,  32'hDEAD_BEEF,  2'b00, 16'd0, 16'd0};
    tbl[3]  = '{1'b1, 32'h0000_0020, 32'h1234_5678,  39'h8,  32'h0,          2'b00, 16'd0, 16'd0};
    tbl[4]  = '{1'b0, 32'h0000_0020, 32'h0,          39'h0,  32'h1234_5678,  2'b01, 16'd1, 16'd0};
    tbl[5]  = '{1'b0, 32'h0000_0020, 32'h0,          39'h0,  32'h1234_5678,  2'b00, 16'd1, 16'd0};
    tbl[6]  = '{1'b1, 32'h0000_0024, 32'hA5A5_A5A5,  39'h18, 32'h0,          2'b00, 16'd1, 16'd0};
    tbl[7]  = '{1'b0, 32'h0000_0024, 32'h0,          39'h0,  32'h0,          2'b10, 16'd1, 16'd1};
    tbl[8]  = '{1'b0, 32'h0000_0013, 32'h0,          39'h0,  32'h0,          2'b11, 16'd1, 16'd1};
    tbl[9]  = '{1'b1, 32'h0000_0400, 32'h1111_1111,  39'h3,  32'h0,          2'b11, 16'd1, 16'd1};
    tbl[10] = '{1'b0, 32'h0000_0000, 32'h0,          39'h0,  32'h0,          2'b00, 16'd1, 16'd1};
    tbl[11] = '{1'b1, 32'h0000_03FC, 32'hCAFE_F00D,  39'h0,  32'h0,          2'b00, 16'd1, 16'd1};
    tbl[12] = '{1'b0, 32'h0000_03FC, 32'h0,          39'h0,  32'hCAFE_F00D,  2'b00, 16'd1, 16'd1};
    tbl[13] = '{1'b0, 32'h0000_0024, 32'h0,          39'h0,  32'h0,          2'b10, 16'd1, 16'd2};
    tbl[14] = '{1'b0, 32'h0000_0002, 32'h0,          39'h0,  32'h0,          2'b11, 16'd1, 16'd2};

    reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
    inject_mask = '0; rsp_ready = 1'b1;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_req_ready", req_ready, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_rdata", rsp_rdata, 0);
    check("rst_rsp_err",   rsp_err,   0);
    check("rst_ce_count",  ce_count,  0);
    check("rst_ue_count",  ue_count,  0);

    reset = 1'b0;
    cnt = 0;
    while (!req_ready && cnt < 2000) begin cnt++; @(negedge clk); end
    check("init_len", cnt, DEPTH);

    foreach (tbl[i]) begin
      txn(tbl[i].w, tbl[i].a, tbl[i].d, tbl[i].m, rd, er, lat);
      check($sformatf("vec%0d_rdata", i), rd, tbl[i].exp_rd);
      check($sformatf("vec%0d_err", i),   er, tbl[i].exp_err);
      check($sformatf("vec%0d_lat", i),   lat, WS + 1);
      check($sformatf("vec%0d_ce", i),    ce_count, tbl[i].exp_ce);
      check($sformatf("vec%0d_ue", i),    ue_count, tbl[i].exp_ue);
    end

    // Backpressure on a correctable read: response and counters must hold, no second scrub.
    txn(1'b1, 32'h34, 32'h0BAD_F00D, 39'h1 << 20, rd, er, lat);
    check("bp_store_err", er, 2'b00);
    rsp_ready = 1'b0;
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h34;
    n = 0;
    while (!req_ready && n < 1000) begin @(negedge clk); n++; end
    @(posedge clk); #1;
    req_valid = 1'b0;
    n = 0;
    while (!rsp_valid && n < 100) begin @(negedge clk); n++; end
    check("bp_valid", rsp_valid, 1);
    hold_rd = rsp_rdata; hold_er = rsp_err;
    check("bp_rdata", hold_rd, 32'h0BAD_F00D);
    check("bp_err",   hold_er, 2'b01);
    check("bp_ce",    ce_count, 16'd2);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_hold_valid", rsp_valid, 1);
      check("bp_hold_rdata", rsp_rdata, 32'h0BAD_F00D);
      check("bp_hold_err",   rsp_err,   2'b01);
      check("bp_hold_ready", req_ready, 0);
      check("bp_hold_ce",    ce_count,  16'd2);
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    check("bp_release_valid", rsp_valid, 0);
    check("bp_release_ready", req_ready, 1);
    txn(1'b0, 32'h34, 32'h0, 39'h0, rd, er, lat);
    check("bp_reread_rdata", rd, 32'h0BAD_F00D);
    check("bp_reread_err",   er, 2'b00);
    check("bp_reread_ce",    ce_count, 16'd2);

    // Reset while a load sits in WAIT: response dropped, counters cleared, sweep repeats.
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h10;
    n = 0;
    while (!req_ready && n < 1000) begin @(negedge clk); n++; end
    @(posedge clk); #1;
    req_valid = 1'b0;
    check("wr_in_wait_valid", rsp_valid, 0);
    reset = 1'b1;
    @(posedge clk); #1;
    check("wr_after_valid", rsp_valid, 0);
    check("wr_after_ready", req_ready, 0);
    check("wr_after_ce",    ce_count,  0);
    check("wr_after_ue",    ue_count,  0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    cnt = 0; saw_valid = 1'b0;
    while (!req_ready && cnt < 2000) begin
      cnt++;
      @(negedge clk);
      if (rsp_valid) saw_valid = 1'b1;
    end
    check("wr_init_len", cnt, DEPTH);
    check("wr_no_rsp",   saw_valid, 0);
    txn(1'b0, 32'h10, 32'h0, 39'h0, rd, er, lat);
    check("wr_swept_rdata", rd, 32'h0);
    check("wr_swept_err",   er, 2'b00);

    // Random traffic against a model of stored words plus their injected fault masks.
    for (int unsigned i = 0; i < DEPTH; i++) begin m_data[i] = '0; m_mask[i] = '0; end
    exp_ce = 0; exp_ue = 0;
    for (int t = 0; t < 300; t++) begin
      logic        w, bad;
      logic [31:0] a, d, exp_rd;
      logic [1:0]  exp_er;
      logic [38:0] m;
      int unsigned widx, r, b1, b2;
      w = 1'($urandom_range(0, 1));
      d = $urandom;
      widx = $urandom_range(0, 31);
      bad = ($urandom_range(0, 9) == 0);
      if (!bad)                       a = 32'(4 * widx);
      else if ($urandom_range(0, 1))  a = 32'(4 * widx + $urandom_range(1, 3));
      else                            a = 32'(4 * DEPTH + 4 * $urandom_range(0, 63));
      r = $urandom_range(0, 5);
      b1 = $urandom_range(0, 38);
      b2 = (b1 + $urandom_range(1, 38)) % 39;
      m = '0;
      if (w && r >= 3) m[b1] = 1'b1;
      if (w && r == 5) m[b2] = 1'b1;
      exp_rd = '0; exp_er = 2'b00;
      if (bad) begin
        exp_er = 2'b11;
      end else if (w) begin
        m_data[widx] = d;
        m_mask[widx] = m;
      end else if ($countones(m_mask[widx]) == 0) begin
        exp_rd = m_data[widx];
      end else if ($countones(m_mask[widx]) == 1) begin
        exp_rd = m_data[widx]; exp_er = 2'b01; exp_ce++;
        m_mask[widx] = '0;
      end else begin
        exp_er = 2'b10; exp_ue++;
      end
      txn(w, a, d, m, rd, er, lat);
      check($sformatf("rnd%0d_rdata", t), rd, exp_rd);
      check($sformatf("rnd%0d_err", t),   er, exp_er);
      check($sformatf("rnd%0d_lat", t),   lat, WS + 1);
      check($sformatf("rnd%0d_ce", t),    ce_count, exp_ce);
      check($sformatf("rnd%0d_ue", t),    ue_count, exp_ue);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/dmem_ecc_responder.md
# dmem_ecc_responder

- Safety-oriented data-memory responder: the target end of the CPU's load/store port.
- Accepts one read or write request at a time over a valid/ready handshake and stores each 32-bit word as a 39-bit SECDED codeword.
- Returns responses after a programmable number of wait states, corrects single-bit errors with scrub-on-read, and flags double-bit and address errors.
- Sits between the CPU data-port adapter and the fault-monitoring logic, which consumes its error counters.

## Interface
- DEPTH_WORDS, 256: number of 32-bit words; power of two, 16..4096.
- WAIT_STATES, 1: extra cycles between accept and response; 0..15.
- clk  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-high.
- req_valid  in  1  request present.
- req_ready  out  1  responder can accept.
- req_write  in  1  1 = store, 0 = load.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  initiator takes the response.
- rsp_rdata  out  32  load data; 0 for stores and errors.
- rsp_err  out  2  00 ok, 01 corrected, 10 uncorrectable, 11 address error.
- ce_count  out  16  corrected-error count, saturating.
- ue_count  out  16  uncorrectable-error count, saturating.
- inject_mask  in  39  XORed into the codeword written by a store accepted this cycle; 0 = no injection.

## Operation
- FSM states: INIT, IDLE, WAIT, RESP.
- INIT
  - Entered on reset.
  - A sweep counter writes the all-zero codeword to words 0..DEPTH_WORDS-1, one per cycle.
  - Moves to IDLE after the last word.
- IDLE
  - req_ready = 1.
  - On req_valid & req_ready: latch write, addr and wdata.
  - If WAIT_STATES = 0, go to RESP; otherwise go to WAIT and load the wait counter.
- WAIT: counter decrements; go to RESP when it reaches 1.
- RESP
  - rsp_valid = 1; hold until rsp_ready, then return to IDLE.
- Address check at accept: addr[1:0] != 0 or addr >= 4*DEPTH_WORDS gives rsp_err = 11, no array access, no counter change.
- Store
  - The encoded codeword XOR inject_mask is written on the accept cycle.
  - Response: rsp_err = 00, rsp_rdata = 0.
- Load
  - On the cycle of entry to RESP, read array[addr], decode, and register rsp_rdata and rsp_err.
- Codeword layout
  - Hamming positions 1..38, with check bits at positions 1, 2, 4, 8, 16, 32 and data in the remaining positions in ascending order.
  - Bit 0 is overall even parity.
- Decode rules
  - Syndrome 0 and parity ok: 00.
  - Parity mismatch and syndrome 0 or 1..38: flip the indicated bit (bit 0 when syndrome is 0), return 01, increment ce_count, write the corrected codeword back in the same cycle.
  - Syndrome != 0 and parity ok, or syndrome > 38: return 10, rdata = 0, increment ue_count, no write-back.
- Counters saturate at 0xFFFF; they are cleared only by reset.

## Timing
- Reset values: req_ready 0, rsp_valid 0, rsp_rdata 0, rsp_err 00, ce_count 0, ue_count 0, state INIT.
- INIT lasts exactly DEPTH_WORDS cycles after reset deasserts; req_ready rises on the next cycle.
- Latency: rsp_valid rises WAIT_STATES+1 cycles after the accept edge.
- Throughput: one outstanding request. req_ready is 0 in WAIT and RESP, so a new accept is possible at the earliest on the cycle after a response handshake.
- Backpressure: while rsp_valid & !rsp_ready, rsp_rdata and rsp_err stay stable, counters do not re-increment, and no second scrub occurs.
- Reset in any state:
  - Pending request and response are dropped, counters clear, and the FSM re-enters INIT.
  - rsp_valid is 0 on the cycle after the reset edge.
- inject_mask is sampled only on a store accept cycle.

## Structure
- Shared package/include fusa_mem_pkg holds:
  - ECC_DATA_W = 32, ECC_CODE_W = 39
  - RSP_OK, RSP_CE, RSP_UE, RSP_ADDR codes
  - FSM state encodings.
- Sub-module ecc_secded_32: purely combinational encode (32→39) and decode (39→data, syndrome, ce, ue). It is reused by future imem protection.
- The top holds the FSM, wait counter, init sweep counter, array, and counters.

## Test plan
- Init: release reset → req_ready stays 0 for 256 cycles, then 1; a read of 0x0 returns 0x00000000, err 00.
- Round-trip: write 0xDEADBEEF to 0x10, read 0x10 → rdata 0xDEADBEEF, err 00, rsp_valid 2 cycles after each accept (WAIT_STATES = 1).
- Single-bit fault:
  - Write 0x12345678 to 0x20 with inject_mask = 1<<3 → first read returns 0x12345678, err 01, ce_count 1.
  - Second read returns err 00; ce_count stays 1.
- Double-bit fault: write 0xA5A5A5A5 to 0x24 with inject_mask = 0x18 → read returns rdata 0, err 10, ue_count 1.
- Address errors: read 0x13 and write 0x400 → err 11, counters unchanged, word 0x0 still reads 0.
- Backpressure and reset:
  - Hold rsp_ready low 5 cycles → rsp_valid, rdata and err stable, req_ready 0.
  - Assert reset during WAIT → no rsp_valid afterwards; init sweep repeats.
